// File: rtl/mixcol_seq.sv
// mixcol_seq: AES MixColumns sequencer, one column per cycle through a shared datapath.
// Define MIXCOL_SEQ_INV_EN to build the inverse datapath and in_inv mode select.
module mixcol_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t r_state, w_next;
  logic [3:0][31:0] r_src, r_res;
  logic [1:0] r_cnt;
  logic [31:0] w_col, w_fwd, w_mix;
  logic w_accept;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

`ifdef MIXCOL_SEQ_INV_EN
  // e/b/d/n hold each input byte times 0e/0b/0d/09
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4], e [4], b [4], d [4], n [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i] = c[31-8*i -: 8];
      x2 = xt(a[i]);
      x4 = xt(x2);
      x8 = xt(x4);
      e[i] = x8 ^ x4 ^ x2;
      b[i] = x8 ^ x2 ^ a[i];
      d[i] = x8 ^ x4 ^ a[i];
      n[i] = x8 ^ a[i];
    end
    return {e[0] ^ b[1] ^ d[2] ^ n[3],
            n[0] ^ e[1] ^ b[2] ^ d[3],
            d[0] ^ n[1] ^ e[2] ^ b[3],
            b[0] ^ d[1] ^ n[2] ^ e[3]};
  endfunction

  logic r_mode;
  always_ff @(posedge clk) begin
    if (rst) r_mode <= 1'b0;
    else if (w_accept) r_mode <= in_inv;
  end
  assign w_mix = r_mode ? inv_col(w_col) : w_fwd;
`else
  logic w_unused_inv;
  assign w_unused_inv = in_inv;
  assign w_mix = w_fwd;
`endif

  // packed index 3 is column 0 (MSB word), hence the inverted counter
  assign w_col = r_src[~r_cnt];
  assign w_fwd = fwd_col(w_col);
  assign w_accept = (r_state == IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = RUN;
    else if (r_state == RUN && r_cnt == 2'd3) w_next = DONE;
    else if (r_state == DONE && out_ready) w_next = IDLE;
  end

  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    busy      = r_state != IDLE;
    out_state = r_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src <= '0;
      r_res <= '0;
      r_cnt <= 2'd0;
    end else if (w_accept) begin
      r_src <= in_state;
      r_cnt <= 2'd0;
    end else if (r_state == RUN) begin
      r_res[~r_cnt] <= w_mix;
      r_cnt <= r_cnt + 2'd1;
    end
  end
endmodule

// File: tb/tb_mixcol_seq.sv
// tb_mixcol_seq: directed stimulus against a GF(2^8) matrix model with a per-cycle scoreboard.
module tb_mixcol_seq;
  logic clk = 0, rst = 1, in_valid = 0, in_inv = 0, out_ready = 1;
  logic [127:0] in_state = '0;
  logic in_ready, out_valid, busy;
  logic [127:0] out_state;

  localparam logic [127:0] ST_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] ST_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] ST_C = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;

  mixcol_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, n_acc = 0, n_out = 0;
  int acc_log[$];
  logic [127:0] q[$];
  logic ov_prev = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // out byte r of each column = sum_k row[(k-r) mod 4] * in byte k
  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [7:0] fr [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [7:0] ir [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] res = '0;
    logic [7:0] cf;
`ifndef MIXCOL_SEQ_INV_EN
    inv = 1'b0;
`endif
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) begin
          cf = inv ? ir[(k - r + 4) % 4] : fr[(k - r + 4) % 4];
          res[127-32*c-8*r -: 8] = res[127-32*c-8*r -: 8] ^ gmul(cf, s[127-32*c-8*k -: 8]);
        end
    return res;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        void'(q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) begin
        q.push_back(mix(in_state, in_inv));
        acc_cyc = cyc;
        acc_log.push_back(cyc);
        n_acc++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_vs_busy", in_ready, !busy);
      if (out_valid) begin
        chk("valid_implies_busy", busy, 1);
        if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else chk("stream_result", out_state, q[0]);
        if (!ov_prev) chk("latency", cyc - acc_cyc, 4);
      end
    end
    ov_prev = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int a0);
    for (int k = 0; k < 50 && n_acc == a0; k++) tick();
    chk("accept_seen", n_acc, a0 + 1);
  endtask

  task automatic send(input logic [127:0] st, input logic inv);
    int a0 = n_acc;
    in_valid = 1;
    in_state = st;
    in_inv = inv;
    wait_acc(a0);
    in_valid = 0;
  endtask

  task automatic wait_out();
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    chk("out_valid_seen", out_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] hold, m;
    int a0, o0;
    m = mix(ST_A, 0);
    chk("model_fwd", m, ST_B);
    m = mix(ST_C, 0);
    chk("model_bp", m[127:64], 128'hd5d5d7d6_4d7ebdf8);
`ifdef MIXCOL_SEQ_INV_EN
    m = mix(ST_B, 1);
    chk("model_inv", m, ST_A);
`endif
    repeat (3) tick();
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_state", out_state, 0);

    send(ST_A, 0);
    wait_out();
    chk("fwd_literal", out_state, ST_B);
    tick();
    chk("ready_after_xfer", in_ready, 1);

    send(ST_B, 1);
    wait_out();
`ifdef MIXCOL_SEQ_INV_EN
    chk("inv_literal", out_state, ST_A);
`endif
    tick();

    send(ST_A, 1);
    wait_out();
`ifndef MIXCOL_SEQ_INV_EN
    chk("inv_ignored_literal", out_state, ST_B);
`endif
    tick();

    // backpressure with a second state waiting on in_valid
    out_ready = 0;
    in_valid = 1;
    in_state = ST_A;
    in_inv = 0;
    wait_acc(n_acc);
    in_state = ST_C;
    wait_out();
    hold = out_state;
    for (int k = 0; k < 5; k++) begin
      chk("bp_stable", out_state, hold);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      tick();
    end
    a0 = n_acc;
    out_ready = 1;
    tick();
    chk("bp_ready_after_xfer", in_ready, 1);
    chk("bp_no_early_accept", n_acc, a0);
    tick();
    chk("bp_accept_next", n_acc, a0 + 1);
    in_valid = 0;
    wait_out();
    chk("bp_second_cols01", out_state[127:64], 128'hd5d5d7d6_4d7ebdf8);
    tick();

    // reset in RUN at E2
    send(ST_A, 0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_state", out_state, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("abort_no_result", out_valid, 0);
    end

    // back-to-back
    o0 = n_out;
    out_ready = 1;
    in_valid = 1;
    in_state = ST_A;
    in_inv = 0;
    wait_acc(n_acc);
    in_state = ST_C;
    wait_acc(n_acc);
    in_valid = 0;
    chk("b2b_interval", acc_log[$] - acc_log[$-1], 6);
    for (int k = 0; k < 20 && busy; k++) tick();
    tick();
    chk("b2b_outputs", n_out - o0, 2);
    chk("b2b_queue_empty", q.size(), 0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mixcol_seq.md
# mixcol_seq

Sequencing controller for the AES MixColumns stage. Accepts a full 128-bit AES state over a valid/ready handshake, pushes its four 32-bit columns one per cycle through a single shared column-mixing datapath (forward or inverse), and reassembles the result. It sits between the ShiftRows and AddRoundKey stages of the iterative round engine. It replaces four parallel column units with one time-shared unit.

## Interface

- Parameters: none. Column count (4) and byte width (8) are fixed by AES.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: input state is valid.
- `in_ready` out 1: block can accept a state. High only in IDLE.
- `in_state` in 128: AES state. Column c = `in_state[127-32c -: 32]`. Byte 0 of a column is its MSB byte (x0 = bits [127:120] for column 0).
- `in_inv` in 1: 1 = inverse MixColumns, 0 = forward. Sampled only at accept.
- `out_valid` out 1: `out_state` holds a complete result.
- `out_ready` in 1: downstream accepts the result.
- `out_state` out 128: mixed state, same column and byte layout as `in_state`.
- `busy` out 1: high in RUN and DONE.

## Operation

- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: capture `in_state` into the source register, capture `in_inv` into the mode register, clear the column counter `cnt` (2 bits), go to RUN.
- **RUN**
  - The shared datapath takes source column `cnt` combinationally.
  - Its result is written into result column `cnt` at the edge.
  - `cnt` increments each cycle. When `cnt`==3, go to DONE (counter wraps to 0).
- **DONE**
  - `out_valid`=1.
  - `out_state` = result register, held stable until the transfer completes.
  - On `out_valid && out_ready`: go to IDLE.
- Datapath arithmetic is GF(2^8) with reduction polynomial 0x11B.
  - Forward matrix rows: [02 03 01 01], rotated per output byte.
  - Inverse matrix rows: [0e 0b 0d 09], rotated per output byte.
  - All results are 8-bit, with no carries leaving a byte.
- No overlap: a new input is never accepted until the previous result has transferred. `in_valid` outside IDLE is ignored.
- Changes to `in_state` or `in_inv` after accept have no effect.
- Reset values: FSM=IDLE, `cnt`=0, `in_ready`=1 in the first cycle after reset, `out_valid`=0, `busy`=0, `out_state`=128'h0, mode=0.
- Reset mid-operation: `rst` in RUN or DONE returns to IDLE at the next edge. The captured state and partial result are discarded, and no `out_valid` pulse is produced.
- Reset has priority over every handshake in the same cycle.

## Timing

- Accept at edge E0. Columns 0..3 are written at edges E1..E4. `out_valid` is high from E4 onward.
- Minimum latency is 4 cycles from accept to `out_valid`.
- With `out_ready` held high, the transfer completes at E5 and `in_ready` is high after E5.
- Minimum initiation interval: 6 cycles per state.
- `out_state` is meaningful only while `out_valid`=1. During RUN the result register holds partial data and must not be sampled.
- `in_ready` and `out_valid` are registered state decodes. There is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration

- Macro: `MIXCOL_SEQ_INV_EN`.
- **Defined:** the inverse datapath and mode register are built, and `in_inv` selects forward or inverse per state.
- **Undefined:**
  - Only the forward datapath is built.
  - `in_inv` is ignored and the mode register is removed.
  - Every state is processed forward.
  - Port list and timing are unchanged.

## Test plan

- **Forward:** `in_state`=db135345_f20a225c_01010101_c6c6c6c6, `in_inv`=0 -> `out_state`=8e4da1bc_9fdc589d_01010101_c6c6c6c6, with `out_valid` exactly 4 cycles after accept.
- **Inverse (macro defined):** `in_state`=8e4da1bc_9fdc589d_01010101_c6c6c6c6, `in_inv`=1 -> `out_state`=db135345_f20a225c_01010101_c6c6c6c6.
- **Backpressure:**
  - Stimulus: hold `out_ready`=0 for 5 cycles in DONE, with `in_valid`=1 carrying d4d4d4d5_2d26314c_... throughout.
  - Required: `out_state` stable, `in_ready`=0, second state not accepted until one cycle after the transfer edge.
  - Then: second result columns 0-1 = d5d5d7d6_4d7ebdf8.
- **Reset mid-RUN:** assert `rst` for one cycle at E2 -> next cycle IDLE, `out_valid`=0, `out_state`=0, `in_ready`=1. No result is ever produced for the aborted state.
- **Macro undefined:** `in_state`=db135345_..., `in_inv`=1 -> forward result 8e4da1bc_... (`in_inv` ignored).
- **Back-to-back with `out_ready`=1:** two consecutive states -> accepts exactly 6 cycles apart, each result correct, no dropped or duplicated `out_valid`.
